// File: rtl/binarizer_adaptive_if.sv
//------------------------------------------------------------------------------
// binarizer_adaptive_if
// Grey-in / bit-out video stream bundle for the adaptive binarizer.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface binarizer_adaptive_if #(
    parameter int DATA_W = 8
);
    logic              pre_vs;
    logic              pre_de;
    logic [DATA_W-1:0] pre_data;
    logic              post_vs;
    logic              post_de;
    logic              post_bit;

    modport master (
        output pre_vs, pre_de, pre_data,
        input  post_vs, post_de, post_bit
    );

    modport slave (
        input  pre_vs, pre_de, pre_data,
        output post_vs, post_de, post_bit
    );
endinterface

`default_nettype wire

// File: rtl/binarizer_adaptive.sv
//------------------------------------------------------------------------------
// binarizer_adaptive
// Grey-to-binary stage with fixed/inverted/window/auto modes. Auto mode
// (macro BINARIZER_AUTO_EN) thresholds on the previous frame mean plus offset.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module binarizer_adaptive #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 22
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              en,
    input  wire logic [1:0]        mode,
    input  wire logic [DATA_W-1:0] thr_lo,
    input  wire logic [DATA_W-1:0] thr_hi,
    input  wire logic [DATA_W:0]   offset,
    binarizer_adaptive_if.slave    vid,
    output logic [DATA_W-1:0]      auto_thr
);

    localparam logic [DATA_W-1:0] c_mean_rst = DATA_W'(1 << (DATA_W - 1));

    logic [DATA_W-1:0] r_s1_data;
    logic              r_s1_vs;
    logic              r_s1_de;
    logic [1:0]        r_s1_mode;
    logic [DATA_W-1:0] r_s1_lo;
    logic [DATA_W-1:0] r_s1_hi;
    logic              r_s2_vs;
    logic              r_s2_de;
    logic              r_s2_bit;
    logic              w_bit;
    logic [DATA_W-1:0] w_cmp_thr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_data <= '0;
            r_s1_vs   <= 1'b0;
            r_s1_de   <= 1'b0;
            r_s1_mode <= 2'b00;
            r_s1_lo   <= '0;
            r_s1_hi   <= '0;
            r_s2_vs   <= 1'b0;
            r_s2_de   <= 1'b0;
            r_s2_bit  <= 1'b0;
        end else begin
            r_s1_data <= vid.pre_data;
            r_s1_vs   <= vid.pre_vs;
            r_s1_de   <= vid.pre_de;
            r_s1_mode <= mode;
            r_s1_lo   <= thr_lo;
            r_s1_hi   <= thr_hi;
            r_s2_vs   <= r_s1_vs;
            r_s2_de   <= r_s1_de;
            r_s2_bit  <= w_bit;
        end
    end

    always_comb begin
        w_bit = 1'b0;
        case (r_s1_mode)
            2'b00:   w_bit = (r_s1_data > r_s1_hi);
            2'b01:   w_bit = (r_s1_data <= r_s1_hi);
            2'b10:   w_bit = (r_s1_lo <= r_s1_hi) && (r_s1_data >= r_s1_lo) &&
                             (r_s1_data <= r_s1_hi);
            default: w_bit = (r_s1_data > w_cmp_thr);
        endcase
    end

    // Bypass is purely combinational; the pipeline keeps running underneath.
    assign vid.post_vs  = en ? r_s2_vs  : vid.pre_vs;
    assign vid.post_de  = en ? r_s2_de  : vid.pre_de;
    assign vid.post_bit = en ? r_s2_bit : 1'b0;

`ifdef BINARIZER_AUTO_EN

    localparam int                c_sum_w    = DATA_W + CNT_W;
    localparam int                c_bit_w    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_BUSY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [DATA_W:0]    r_s1_offset;
    logic [c_sum_w-1:0] r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic [c_sum_w-1:0] r_div_sum;
    logic [CNT_W-1:0]   r_div_cnt;
    logic [CNT_W-1:0]   r_rem;
    logic [DATA_W-1:0]  r_quo;
    logic [c_bit_w-1:0] r_bits;
    logic [DATA_W-1:0]  r_mean;

    logic               w_vs_rise;
    logic               w_frame_ok;
    logic [CNT_W:0]     w_trial;
    logic [CNT_W:0]     w_diff;
    logic               w_qbit;
    logic [CNT_W-1:0]   w_rem_next;
    logic               w_rem_unused;

    function automatic logic [DATA_W-1:0] sat_thr(input logic [DATA_W-1:0] m,
                                                  input logic [DATA_W:0]   off);
        logic signed [DATA_W+1:0] s;
        s = $signed({2'b00, m}) + $signed({off[DATA_W], off});
        if (s[DATA_W+1])
            return '0;
        else if (s[DATA_W])
            return '1;
        else
            return s[DATA_W-1:0];
    endfunction

    assign w_vs_rise  = vid.pre_vs & ~r_s1_vs;
    assign w_frame_ok = (r_cnt != '0) && !r_ovf;
    assign w_cmp_thr  = sat_thr(r_mean, r_s1_offset);
    assign auto_thr   = sat_thr(r_mean, offset);

    // Remainder starts at sum>>DATA_W, which is always below cnt because the
    // mean fits in DATA_W bits; only DATA_W restoring steps are then needed.
    assign w_trial = {r_rem, r_quo[DATA_W-1]};
    assign w_diff  = w_trial - {1'b0, r_div_cnt};
    assign w_qbit  = (w_trial >= {1'b0, r_div_cnt});
    assign {w_rem_unused, w_rem_next} = w_qbit ? w_diff : w_trial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_s1_offset <= '0;
        else
            r_s1_offset <= offset;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_vs_rise) begin
            r_sum <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (vid.pre_de) begin
            if (r_cnt == c_cnt_max) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_sum <= r_sum + c_sum_w'(vid.pre_data);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_div_sum <= '0;
            r_div_cnt <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_bits    <= '0;
            r_mean    <= c_mean_rst;
        end else if (w_vs_rise) begin
            // Latest frame wins: any divide in flight is dropped.
            if (w_frame_ok) begin
                r_div_sum <= r_sum;
                r_div_cnt <= r_cnt;
                r_state   <= S_LOAD;
            end else begin
                r_state   <= S_IDLE;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_rem   <= r_div_sum[c_sum_w-1:DATA_W];
                    r_quo   <= r_div_sum[DATA_W-1:0];
                    r_bits  <= '0;
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    r_rem  <= w_rem_next;
                    r_quo  <= {r_quo[DATA_W-2:0], w_qbit};
                    r_bits <= r_bits + c_bit_w'(1);
                    if (r_bits == c_last_bit)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    if (!vid.pre_de) begin
                        r_mean  <= r_quo;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`else

    logic w_unused_offset;

    assign w_cmp_thr       = r_s1_hi;
    assign auto_thr        = c_mean_rst;
    assign w_unused_offset = ^offset;

`endif

endmodule

`default_nettype wire

// File: tb/tb_binarizer_adaptive.sv
//------------------------------------------------------------------------------
// tb_binarizer_adaptive
// Scoreboard bench: driver queues expected bits, monitor pops on post_de.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_binarizer_adaptive;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] thr_lo = '0;
    logic [DW-1:0] thr_hi = 8'd100;
    logic [DW:0]   offset = '0;
    logic [DW-1:0] auto_thr;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        logic b;
        logic vs;
        int   cyc;
        int   lat;
    } exp_t;

    exp_t q[$];

    binarizer_adaptive_if #(.DATA_W(DW)) vif ();

    binarizer_adaptive #(.DATA_W(DW), .CNT_W(22)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .thr_lo   (thr_lo),
        .thr_hi   (thr_hi),
        .offset   (offset),
        .vid      (vif),
        .auto_thr (auto_thr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic vs, input logic eb);
        exp_t e;
        @(posedge clk); #1;
        vif.pre_data = d;
        vif.pre_vs   = vs;
        vif.pre_de   = 1'b1;
        e.b   = eb;
        e.vs  = vs;
        e.cyc = cyc;
        e.lat = en ? 2 : 0;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            vif.pre_de = 1'b0;
            vif.pre_vs = 1'b0;
        end
    endtask

    task automatic vs_rise();
        @(posedge clk); #1;
        vif.pre_de = 1'b0;
        vif.pre_vs = 1'b1;
        @(posedge clk); #1;
        vif.pre_vs = 1'b0;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && vif.post_de) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: post_de=1 got, expected no output");
                end else begin
                    e = q.pop_front();
                    check("sb_bit", int'(vif.post_bit), int'(e.b));
                    check("sb_vs", int'(vif.post_vs), int'(e.vs));
                    check("sb_latency", cyc - e.cyc, e.lat);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vif.pre_vs   = 1'b0;
        vif.pre_de   = 1'b0;
        vif.pre_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_post_vs", int'(vif.post_vs), 0);
        check("rst_post_de", int'(vif.post_de), 0);
        check("rst_post_bit", int'(vif.post_bit), 0);
        check("rst_auto_thr", int'(auto_thr), 128);
        rst_n = 1'b1;

        // Fixed mode, vs travels with the first pixel
        mode = 2'b00; thr_hi = 8'd100;
        send(8'd99, 1'b1, 1'b0);
        send(8'd100, 1'b0, 1'b0);
        send(8'd101, 1'b0, 1'b1);
        idle(4);

        // Inverted
        mode = 2'b01;
        send(8'd100, 1'b0, 1'b1);
        send(8'd101, 1'b0, 1'b0);
        idle(3);

        // Window, then inverted bounds
        mode = 2'b10; thr_lo = 8'd50; thr_hi = 8'd60;
        send(8'd49, 1'b0, 1'b0);
        send(8'd50, 1'b0, 1'b1);
        send(8'd60, 1'b0, 1'b1);
        send(8'd61, 1'b0, 1'b0);
        idle(3);
        thr_lo = 8'd70;
        send(8'd65, 1'b0, 1'b0);
        send(8'd60, 1'b0, 1'b0);
        send(8'd70, 1'b0, 1'b0);
        idle(4);

`ifndef BINARIZER_AUTO_EN
        // Without the statistics engine, mode 11 is a plain fixed threshold
        mode = 2'b11; thr_hi = 8'd100;
        send(8'd101, 1'b0, 1'b1);
        send(8'd100, 1'b0, 1'b0);
        idle(3);
        check("noauto_thr", int'(auto_thr), 128);
        offset = 9'd20;
        #1;
        check("noauto_thr_off", int'(auto_thr), 128);
        offset = '0;
`endif

        // Bypass
        en = 1'b0; mode = 2'b00; thr_hi = 8'd100;
        send(8'd200, 1'b1, 1'b0);
        #1;
        check("byp_vs", int'(vif.post_vs), 1);
        check("byp_de", int'(vif.post_de), 1);
        check("byp_bit", int'(vif.post_bit), 0);
        send(8'd50, 1'b0, 1'b0);
        idle(1);
        #1;
        check("byp_de_low", int'(vif.post_de), 0);
        idle(3);
        en = 1'b1;
        idle(2);

`ifdef BINARIZER_AUTO_EN
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        mode = 2'b11; offset = '0;
        check("auto_rst_thr", int'(auto_thr), 128);

        // Mean of 10,20,30,41 = floor(101/4) = 25
        send(8'd10, 1'b0, 1'b0);
        send(8'd20, 1'b0, 1'b0);
        send(8'd30, 1'b0, 1'b0);
        send(8'd41, 1'b0, 1'b0);
        vs_rise();
        repeat (DW + 2) @(posedge clk);
        #1;
        check("auto_mean25", int'(auto_thr), 25);

        // Frame 25,26,249,250: mean floor(550/4) = 137
        send(8'd25, 1'b0, 1'b0);
        send(8'd26, 1'b0, 1'b1);
        send(8'd249, 1'b0, 1'b1);
        send(8'd250, 1'b0, 1'b1);
        vs_rise();
        // de held high through DONE; these 250s form the next frame
        repeat (DW + 6) send(8'd250, 1'b0, 1'b1);
        check("hold_done_thr", int'(auto_thr), 25);
        idle(1);
        check("hold_pre_release", int'(auto_thr), 25);
        @(posedge clk); #1;
        check("hold_released", int'(auto_thr), 137);
        idle(2);

        vs_rise();
        repeat (DW + 2) @(posedge clk);
        #1;
        check("mean250", int'(auto_thr), 250);
        offset = 9'd20;
        #1;
        check("sat_hi", int'(auto_thr), 255);
        offset = 9'h1EC;
        #1;
        check("mean250_m20", int'(auto_thr), 230);
        offset = '0;

        send(8'd5, 1'b0, 1'b0);
        send(8'd5, 1'b0, 1'b0);
        send(8'd5, 1'b0, 1'b0);
        vs_rise();
        repeat (DW + 2) @(posedge clk);
        #1;
        offset = 9'h1EC;
        #1;
        check("sat_lo", int'(auto_thr), 0);
        offset = 9'd20;
        #1;
        check("mean5_p20", int'(auto_thr), 25);
        offset = '0;

        // Empty frame leaves the mean alone
        vs_rise();
        repeat (DW + 4) @(posedge clk);
        #1;
        check("empty_frame", int'(auto_thr), 5);

        // Reset while the divider is busy
        send(8'd100, 1'b0, 1'b1);
        send(8'd100, 1'b0, 1'b1);
        vs_rise();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("busy_rst_thr", int'(auto_thr), 128);
        check("busy_rst_vs", int'(vif.post_vs), 0);
        check("busy_rst_de", int'(vif.post_de), 0);
        check("busy_rst_bit", int'(vif.post_bit), 0);
        idle(1);
        rst_n = 1'b1;
        idle(DW + 4);
        check("busy_rst_after", int'(auto_thr), 128);
`endif

        idle(4);
        check("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
